// File: rtl/debug_jtag_vji_driver.sv
// Virtual-JTAG initiator for the Nios II debug slave: steps UIR, CDR, SDR x DR_WIDTH, UDR and RTI,
// shifting cmd_dr out on tdi LSB-first while capturing tdo, then returns the captured DR and IR readback.
module debug_jtag_vji_driver #(
  parameter int DR_WIDTH  = 38,
  parameter int IR_WIDTH  = 2,
  parameter int TCK_DIV   = 4,
  parameter int RTI_STEPS = 2
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_cmd_valid,
  output logic                o_cmd_ready,
  input  logic [IR_WIDTH-1:0] i_cmd_ir,
  input  logic [DR_WIDTH-1:0] i_cmd_dr,
  output logic                o_rsp_valid,
  input  logic                i_rsp_ready,
  output logic [DR_WIDTH-1:0] o_rsp_dr,
  output logic [IR_WIDTH-1:0] o_rsp_ir_out,
  output logic [IR_WIDTH-1:0] o_vji_ir_in,
  input  logic [IR_WIDTH-1:0] i_vji_ir_out,
  output logic                o_vji_uir,
  output logic                o_vji_cdr,
  output logic                o_vji_sdr,
  output logic                o_vji_udr,
  output logic                o_vji_rti,
  output logic                o_vji_tck_en,
  output logic                o_vji_tdi,
  input  logic                i_vji_tdo
);
  localparam int BW = (DR_WIDTH > 1) ? $clog2(DR_WIDTH) : 1;
  localparam logic [7:0]    DIV_LAST = 8'(TCK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DR_WIDTH - 1);
  localparam logic [3:0]    RTI_LAST = 4'(RTI_STEPS - 1);

  typedef enum logic [2:0] {S_IDLE, S_UIR, S_CDR, S_SDR, S_UDR, S_RTI, S_RSP} state_t;

  state_t              r_state;
  logic [7:0]          r_div;
  logic [BW-1:0]       r_bit;
  logic [3:0]          r_rti;
  logic [DR_WIDTH-1:0] r_sr;
  logic [DR_WIDTH-1:0] r_rsp_dr;
  logic [IR_WIDTH-1:0] r_rsp_ir;
  logic [IR_WIDTH-1:0] r_ir_in;
  logic                r_cmd_ready, r_rsp_valid;
  logic                r_uir, r_cdr, r_sdr, r_udr, r_rti_s;
  logic                w_step, w_tck_en;

  assign w_step   = (r_state != S_IDLE) && (r_state != S_RSP);
  assign w_tck_en = w_step && (r_div == DIV_LAST);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_div       <= '0;
      r_bit       <= '0;
      r_rti       <= '0;
      r_sr        <= '0;
      r_rsp_dr    <= '0;
      r_rsp_ir    <= '0;
      r_ir_in     <= '0;
      r_cmd_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_uir       <= 1'b0;
      r_cdr       <= 1'b0;
      r_sdr       <= 1'b0;
      r_udr       <= 1'b0;
      r_rti_s     <= 1'b0;
    end else begin
      if (w_step) r_div <= w_tck_en ? 8'd0 : r_div + 8'd1;
      else        r_div <= 8'd0;
      case (r_state)
        S_IDLE: begin
          r_cmd_ready <= 1'b1;
          if (i_cmd_valid && r_cmd_ready) begin
            r_cmd_ready <= 1'b0;
            r_ir_in     <= i_cmd_ir;
            r_sr        <= i_cmd_dr;
            r_bit       <= '0;
            r_rti       <= '0;
            r_uir       <= 1'b1;
            r_state     <= S_UIR;
          end
        end
        S_UIR: if (w_tck_en) begin
          r_rsp_ir <= i_vji_ir_out;
          r_uir    <= 1'b0;
          r_cdr    <= 1'b1;
          r_state  <= S_CDR;
        end
        S_CDR: if (w_tck_en) begin
          r_cdr   <= 1'b0;
          r_sdr   <= 1'b1;
          r_state <= S_SDR;
        end
        S_SDR: if (w_tck_en) begin
          // tdo enters at the top so the first captured bit ends up in bit 0
          r_sr  <= {i_vji_tdo, r_sr[DR_WIDTH-1:1]};
          r_bit <= r_bit + 1'b1;
          if (r_bit == BIT_LAST) begin
            r_sdr   <= 1'b0;
            r_udr   <= 1'b1;
            r_state <= S_UDR;
          end
        end
        S_UDR: if (w_tck_en) begin
          r_udr   <= 1'b0;
          r_rti_s <= 1'b1;
          r_state <= S_RTI;
        end
        S_RTI: if (w_tck_en) begin
          r_rti <= r_rti + 4'd1;
          if (r_rti == RTI_LAST) begin
            r_rti_s     <= 1'b0;
            r_rsp_dr    <= r_sr;
            r_rsp_valid <= 1'b1;
            r_state     <= S_RSP;
          end
        end
        S_RSP: if (i_rsp_ready) begin
          r_rsp_valid <= 1'b0;
          r_cmd_ready <= 1'b1;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_cmd_ready  = r_cmd_ready;
  assign o_rsp_valid  = r_rsp_valid;
  assign o_rsp_dr     = r_rsp_dr;
  assign o_rsp_ir_out = r_rsp_ir;
  assign o_vji_ir_in  = r_ir_in;
  assign o_vji_uir    = r_uir;
  assign o_vji_cdr    = r_cdr;
  assign o_vji_sdr    = r_sdr;
  assign o_vji_udr    = r_udr;
  assign o_vji_rti    = r_rti_s;
  assign o_vji_tck_en = w_tck_en;
  assign o_vji_tdi    = r_sdr & r_sr[0];
endmodule

// File: tb/tb_debug_jtag_vji_driver.sv
// Randomized bench: a slave model (tdo echo or random pattern) and a step-level protocol model
// check strobe order, step timing, shifted data, latency and response handshake.
module tb_debug_jtag_vji_driver;
  localparam int DRW = 38, IRW = 2, DIV = 4, RTI = 2;
  localparam int NSTEP = 3 + DRW + RTI;
  localparam int LAT   = 1 + DIV * NSTEP;
  localparam int LAT1  = 1 + NSTEP;

  logic gclk = 0;
  always #5 gclk = ~gclk;

  logic reset = 1;
  logic cmd_valid = 0, cmd_ready, rsp_valid, rsp_ready = 0;
  logic [IRW-1:0] cmd_ir = 0, rsp_ir, ir_in, ir_out = 0;
  logic [DRW-1:0] cmd_dr = 0, rsp_dr, pat = 0;
  logic uir, cdr, sdr, udr, rti, tck_en, tdi, tdo;
  logic mode = 0;
  int   k = 0;

  assign tdo = mode ? ((k < DRW) ? pat[k] : 1'b0) : tdi;

  debug_jtag_vji_driver #(.DR_WIDTH(DRW), .IR_WIDTH(IRW), .TCK_DIV(DIV), .RTI_STEPS(RTI)) u_dut (
    .i_clk(gclk), .i_reset(reset), .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
    .i_cmd_ir(cmd_ir), .i_cmd_dr(cmd_dr), .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
    .o_rsp_dr(rsp_dr), .o_rsp_ir_out(rsp_ir), .o_vji_ir_in(ir_in), .i_vji_ir_out(ir_out),
    .o_vji_uir(uir), .o_vji_cdr(cdr), .o_vji_sdr(sdr), .o_vji_udr(udr), .o_vji_rti(rti),
    .o_vji_tck_en(tck_en), .o_vji_tdi(tdi), .i_vji_tdo(tdo));

  logic v1 = 0, rdy1, rv1, rr1 = 1;
  logic [IRW-1:0] ir1 = 0, rir1, iri1, iro1 = 2'b01;
  logic [DRW-1:0] dr1 = 0, rdr1;
  logic uir1, cdr1, sdr1, udr1, rti1, tck1, tdi1;

  debug_jtag_vji_driver #(.DR_WIDTH(DRW), .IR_WIDTH(IRW), .TCK_DIV(1), .RTI_STEPS(RTI)) u_dut1 (
    .i_clk(gclk), .i_reset(reset), .i_cmd_valid(v1), .o_cmd_ready(rdy1),
    .i_cmd_ir(ir1), .i_cmd_dr(dr1), .o_rsp_valid(rv1), .i_rsp_ready(rr1),
    .o_rsp_dr(rdr1), .o_rsp_ir_out(rir1), .o_vji_ir_in(iri1), .i_vji_ir_out(iro1),
    .o_vji_uir(uir1), .o_vji_cdr(cdr1), .o_vji_sdr(sdr1), .o_vji_udr(udr1), .o_vji_rti(rti1),
    .o_vji_tck_en(tck1), .o_vji_tdi(tdi1), .i_vji_tdo(tdi1));

  int vecs = 0, errs = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [4:0] exp_code(input int i);
    if (i == 0)            return 5'b10000;
    else if (i == 1)       return 5'b01000;
    else if (i < 2 + DRW)  return 5'b00100;
    else if (i == 2 + DRW) return 5'b00010;
    else                   return 5'b00001;
  endfunction

  // slave-side bit index: number of SDR steps completed in the current command
  always @(posedge gclk) begin
    if (cmd_valid && cmd_ready) k <= 0;
    else if (tck_en && sdr)     k <= k + 1;
  end

  logic [4:0] steps[$];
  logic       tdi_q[$];
  logic [4:0] code, prev = 0;
  int len = 0, udr_cnt = 0;
  bit same = 1;

  always @(negedge gclk) begin
    code = {uir, cdr, sdr, udr, rti};
    if (cmd_valid && cmd_ready) begin
      steps.delete();
      tdi_q.delete();
    end
    if (code != 0) chk("onehot", 64'($countones(code) == 1), 1);
    if (code == 0) begin
      len = 0;
      same = 1;
      chk("tck_idle", tck_en, 0);
    end else begin
      if (len > 0 && code != prev) same = 0;
      len++;
      prev = code;
      if (tck_en) begin
        chk("step_len", len, DIV);
        chk("step_const", same, 1);
        steps.push_back(code);
        if (sdr) tdi_q.push_back(tdi);
        len = 0;
        same = 1;
      end
    end
    if (!sdr) chk("tdi_zero", tdi, 0);
    if (udr) udr_cnt++;
  end

  task automatic run_cmd(input logic [IRW-1:0] ir, input logic [DRW-1:0] dr, input logic m,
                         input logic [DRW-1:0] p, input int hold, input logic [IRW-1:0] iro);
    int n;
    logic [DRW-1:0] exp, tv;
    @(negedge gclk);
    mode = m; pat = p; ir_out = iro;
    exp = m ? p : dr;
    n = 0;
    while (!cmd_ready && n < 20) begin @(negedge gclk); n++; end
    chk("ready", cmd_ready, 1);
    cmd_valid = 1; cmd_ir = ir; cmd_dr = dr;
    n = 0;
    do begin
      @(negedge gclk); n++;
      if (n == 1) begin
        cmd_valid = 0; cmd_ir = IRW'($urandom); cmd_dr = DRW'({$urandom, $urandom});
        chk("uir_start", uir, 1);
        chk("ir_in", ir_in, ir);
      end
      if (n == 1 + DIV) ir_out = ~iro;
    end while (!rsp_valid && n < 400);
    chk("latency", n, LAT);
    chk("rsp_dr", rsp_dr, exp);
    chk("rsp_ir", rsp_ir, iro);
    chk("nsteps", steps.size(), NSTEP);
    for (int i = 0; i < steps.size() && i < NSTEP; i++) chk("step_order", steps[i], exp_code(i));
    chk("ntdi", tdi_q.size(), DRW);
    tv = '0;
    for (int i = 0; i < tdi_q.size() && i < DRW; i++) tv[i] = tdi_q[i];
    chk("tdi_bits", tv, dr);
    for (int h = 0; h < hold; h++) begin
      if (h == hold / 2) begin cmd_valid = 1; cmd_ir = ~ir; cmd_dr = ~dr; end
      @(negedge gclk);
      cmd_valid = 0;
      chk("hold_valid", rsp_valid, 1);
      chk("hold_dr", rsp_dr, exp);
      chk("hold_ir", rsp_ir, iro);
      chk("hold_ready", cmd_ready, 0);
    end
    rsp_ready = 1;
    @(negedge gclk);
    rsp_ready = 0;
    chk("rsp_drop", rsp_valid, 0);
    chk("ready_back", cmd_ready, 1);
    chk("ir_in_held", ir_in, ir);
    @(negedge gclk);
    chk("no_relatch", uir, 0);
    chk("ir_in_held2", ir_in, ir);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, u0;
    logic [DRW-1:0] a, b;
    repeat (3) @(negedge gclk);
    chk("rst_ready", cmd_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_dr", rsp_dr, 0);
    chk("rst_rsp_ir", rsp_ir, 0);
    chk("rst_ir_in", ir_in, 0);
    chk("rst_pins", {uir, cdr, sdr, udr, rti, tck_en, tdi}, 0);
    reset = 0;
    @(negedge gclk);
    chk("ready_after_rst", cmd_ready, 1);

    run_cmd(2'b01, 38'h2_A5A5_A5A5, 0, '0, 3, 2'b00);
    run_cmd(2'b11, '0, 1, '1, 20, 2'b10);
    for (int t = 0; t < 6; t++)
      run_cmd(IRW'($urandom), DRW'({$urandom, $urandom}), 1'($urandom), DRW'({$urandom, $urandom}),
              $urandom_range(1, 6), IRW'($urandom));

    // reset in the middle of SDR must abort without any UDR step
    @(negedge gclk);
    mode = 0;
    n = 0;
    while (!cmd_ready && n < 20) begin @(negedge gclk); n++; end
    cmd_valid = 1; cmd_dr = DRW'({$urandom, $urandom}); cmd_ir = 2'b10;
    @(negedge gclk);
    cmd_valid = 0;
    n = 0;
    while (!(sdr && k == 17) && n < 400) begin @(negedge gclk); n++; end
    chk("reach_bit17", 64'(sdr && k == 17), 1);
    u0 = udr_cnt;
    reset = 1;
    @(negedge gclk);
    reset = 0;
    chk("mid_rst_pins", {uir, cdr, sdr, udr, rti, tck_en}, 0);
    chk("mid_rst_rsp", rsp_valid, 0);
    repeat (DIV * 8) @(negedge gclk);
    chk("no_udr", udr_cnt, u0);
    chk("mid_rst_idle", {uir, cdr, sdr, udr, rti, rsp_valid}, 0);
    run_cmd(2'b01, DRW'({$urandom, $urandom}), 1, DRW'({$urandom, $urandom}), 2, 2'b11);

    // TCK_DIV=1 instance: loopback slave, back-to-back with rsp_ready held high
    a = DRW'({$urandom, $urandom});
    b = DRW'({$urandom, $urandom});
    n = 0;
    while (!rdy1 && n < 20) begin @(negedge gclk); n++; end
    v1 = 1; dr1 = a; ir1 = 2'b10;
    n = 0;
    do begin
      @(negedge gclk); n++;
      if (n == 1) v1 = 0;
    end while (!rv1 && n < 200);
    chk("lat1_a", n, LAT1);
    chk("dr1_a", rdr1, a);
    chk("ir1_a", rir1, iro1);
    v1 = 1; dr1 = b; ir1 = 2'b01;
    @(negedge gclk);
    chk("b2b_ready", rdy1, 1);
    chk("b2b_rsp_drop", rv1, 0);
    @(negedge gclk);
    chk("b2b_uir", uir1, 1);
    chk("b2b_ir_in", iri1, 2'b01);
    v1 = 0;
    n = 1;
    while (!rv1 && n < 200) begin @(negedge gclk); n++; end
    chk("lat1_b", n, LAT1);
    chk("dr1_b", rdr1, b);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
